// File: rtl/crossing_pkg.sv
// -----------------------------------------------------------------------------
// crossing_pkg
// Shared definitions for the pedestrian crossing controller:
//   - state_t     : FSM state encoding (also visible on the STATE debug port)
//   - DEF_*       : default timing constants used as parameter defaults
//   - timer_width : width of the per-state tick timer
// -----------------------------------------------------------------------------
package crossing_pkg;

    typedef enum logic [2:0] {
        ST_CGRN  = 3'd0,
        ST_CYEL  = 3'd1,
        ST_RED1  = 3'd2,
        ST_WALK  = 3'd3,
        ST_FLASH = 3'd4,
        ST_RED2  = 3'd5
    } state_t;

    localparam int DEF_TICK_DIV      = 1000;
    localparam int DEF_CAR_GREEN_MIN = 20;
    localparam int DEF_CAR_YEL_T     = 3;
    localparam int DEF_ALL_RED_T     = 2;
    localparam int DEF_WALK_BASE     = 8;
    localparam int DEF_RAND_BITS     = 3;
    localparam int DEF_FLASH_T       = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The timer counts ticks from 0 and must hold the longest state length.
    // In car-green it parks at the minimum-green count, so that value itself
    // has to be representable too.
    function automatic int timer_width(input int green_min, input int yel_t,
                                       input int all_red_t, input int walk_max,
                                       input int flash_t);
        int m;
        m = max_int(max_int(green_min, yel_t), max_int(all_red_t, flash_t));
        m = max_int(m, walk_max);
        return max_int($clog2(m + 1), 1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler producing one timing tick every DIV clock cycles.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_clr   : synchronous clear; the next cycle starts a fresh tick period
//   o_tick  : high for one cycle at the end of each DIV-cycle period
// -----------------------------------------------------------------------------
module tick_gen
    import crossing_pkg::*;
#(
    parameter int DIV = DEF_TICK_DIV
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DIV - 1));
    assign o_tick = w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/crossing_ctrl.sv
// -----------------------------------------------------------------------------
// crossing_ctrl
// Pedestrian crossing controller: car lamps stay green for at least
// CAR_GREEN_MIN ticks, then a latched push-button request runs one crossing
// cycle CGRN -> CYEL -> RED1 -> WALK -> FLASH -> RED2 -> CGRN.
//   CLK          : clock, rising edge
//   RST          : asynchronous active-low reset
//   PED_BTN      : asynchronous push-button, active-high
//   RANDOM_WORD  : random word; low RAND_BITS extend the walk time
//   RAND_EN      : one-cycle pulse advancing the random generator
//   CAR_RED/YEL/GRN, PED_RED/GRN : lamps (registered)
//   PED_WAIT     : request latched (registered)
//   STATE        : current FSM state code
// -----------------------------------------------------------------------------
module crossing_ctrl
    import crossing_pkg::*;
#(
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int CAR_GREEN_MIN = DEF_CAR_GREEN_MIN,
    parameter int CAR_YEL_T     = DEF_CAR_YEL_T,
    parameter int ALL_RED_T     = DEF_ALL_RED_T,
    parameter int WALK_BASE     = DEF_WALK_BASE,
    parameter int RAND_BITS     = DEF_RAND_BITS,
    parameter int FLASH_T       = DEF_FLASH_T
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PED_BTN,
    input  logic [15:0] RANDOM_WORD,
    output logic        RAND_EN,
    output logic        CAR_RED,
    output logic        CAR_YEL,
    output logic        CAR_GRN,
    output logic        PED_RED,
    output logic        PED_GRN,
    output logic        PED_WAIT,
    output logic [2:0]  STATE
);

    localparam int WALK_MAX = WALK_BASE + (1 << RAND_BITS) - 1;
    localparam int TW       = timer_width(CAR_GREEN_MIN, CAR_YEL_T, ALL_RED_T,
                                          WALK_MAX, FLASH_T);

    state_t        r_state;
    state_t        w_next;
    logic          r_sync1, r_sync2, r_sync3;
    logic          r_req;
    logic          r_min_done;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] r_dur;
    logic          w_tick;
    logic          w_enter;
    logic          w_btn_edge;
    logic          w_min_hit;
    logic          w_walk_go;
    logic          w_req_open;
    logic          w_rand_unused;

    // Only the low RAND_BITS of the random word are consumed.
    assign w_rand_unused = ^RANDOM_WORD[15:RAND_BITS];

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_clr   (w_enter),
        .o_tick  (w_tick)
    );

    assign w_btn_edge = r_sync2 & ~r_sync3;
    assign w_min_hit  = (r_state == ST_CGRN) && w_tick &&
                        (r_timer == TW'(CAR_GREEN_MIN - 1));
    assign w_walk_go  = (r_state == ST_RED1) && (w_next == ST_WALK);
    assign w_enter    = (w_next != r_state);
    assign w_req_open = (r_state == ST_CGRN) || (r_state == ST_CYEL) ||
                        (r_state == ST_RED1) || (r_state == ST_RED2);

    // The minimum-green completion counts on the very tick it happens, so a
    // request already waiting leaves green exactly CAR_GREEN_MIN ticks in.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CGRN:  if ((r_min_done || w_min_hit) && r_req) w_next = ST_CYEL;
            ST_CYEL:  if (w_tick && (r_timer == TW'(CAR_YEL_T - 1))) w_next = ST_RED1;
            ST_RED1:  if (w_tick && (r_timer == TW'(ALL_RED_T - 1))) w_next = ST_WALK;
            ST_WALK:  if (w_tick && (r_timer == r_dur - TW'(1)))     w_next = ST_FLASH;
            ST_FLASH: if (w_tick && (r_timer == TW'(FLASH_T - 1)))   w_next = ST_RED2;
            ST_RED2:  if (w_tick && (r_timer == TW'(ALL_RED_T - 1))) w_next = ST_CGRN;
            default:  w_next = ST_CGRN;
        endcase
    end

    // Button synchronizer, edge detector and request latch. Consuming the
    // request at RED1->WALK wins over a simultaneous new edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_sync1 <= PED_BTN;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (w_walk_go) begin
                r_req <= 1'b0;
            end else if (w_btn_edge && w_req_open) begin
                r_req <= 1'b1;
            end
        end
    end

    // Per-state tick timer. It freezes in car-green once the minimum is met
    // so it cannot wrap while waiting for a request.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_timer    <= '0;
            r_min_done <= 1'b0;
            r_dur      <= '0;
        end else begin
            if (w_enter) begin
                r_timer <= '0;
            end else if (w_tick && !((r_state == ST_CGRN) && r_min_done)) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_enter) begin
                r_min_done <= 1'b0;
            end else if (w_min_hit) begin
                r_min_done <= 1'b1;
            end
            if (w_walk_go) begin
                r_dur <= TW'(WALK_BASE) + TW'(RANDOM_WORD[RAND_BITS-1:0]);
            end
        end
    end

    // State register plus lamp outputs decoded from the next state, so the
    // lamps change on the same edge as STATE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_CGRN;
            CAR_RED <= 1'b0;
            CAR_YEL <= 1'b0;
            CAR_GRN <= 1'b1;
            PED_RED <= 1'b1;
            PED_GRN <= 1'b0;
            RAND_EN <= 1'b0;
        end else begin
            r_state <= w_next;
            CAR_GRN <= (w_next == ST_CGRN);
            CAR_YEL <= (w_next == ST_CYEL);
            CAR_RED <= (w_next != ST_CGRN) && (w_next != ST_CYEL);
            PED_RED <= (w_next != ST_WALK) && (w_next != ST_FLASH);
            RAND_EN <= w_walk_go;
            case (w_next)
                ST_WALK:  PED_GRN <= 1'b1;
                ST_FLASH: begin
                    if (r_state != ST_FLASH) begin
                        PED_GRN <= 1'b1;
                    end else if (w_tick) begin
                        PED_GRN <= ~PED_GRN;
                    end
                end
                default:  PED_GRN <= 1'b0;
            endcase
        end
    end

    assign PED_WAIT = r_req;
    assign STATE    = r_state;

endmodule

// File: doc/crossing_ctrl.md
CROSSING_CTRL -- requirements
Module: crossing_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1000, meaning CLK cycles per timing tick (minimum 2).
REQ-002 The block SHALL have parameter CAR_GREEN_MIN, default 20, meaning minimum car-green ticks.
REQ-003 The block SHALL have parameter CAR_YEL_T, default 3, meaning car-yellow ticks.
REQ-004 The block SHALL have parameter ALL_RED_T, default 2, meaning ticks per all-red interval.
REQ-005 The block SHALL have parameter WALK_BASE, default 8, meaning base pedestrian-walk ticks.
REQ-006 The block SHALL have parameter RAND_BITS, default 3, meaning RANDOM_WORD LSBs added to the walk time.
REQ-007 The block SHALL have parameter FLASH_T, default 4, meaning pedestrian-flash ticks.
REQ-008 The block SHALL have port CLK  in  1  the single clock; all logic is on its rising edge.
REQ-009 The block SHALL have port RST  in  1  asynchronous, active-low reset.
REQ-010 The block SHALL have port PED_BTN  in  1  asynchronous pedestrian push-button, active-high.
REQ-011 The block SHALL have port RANDOM_WORD  in  16  the word from the upstream random1 generator.
REQ-012 The block SHALL have port RAND_EN  out  1  a one-cycle pulse that drives random1 ENABLE to advance it.
REQ-013 The block SHALL have ports CAR_RED, CAR_YEL, CAR_GRN  out  1 each, the car lamps.
REQ-014 The block SHALL have ports PED_RED, PED_GRN  out  1 each, the pedestrian lamps.
REQ-015 The block SHALL have port PED_WAIT  out  1  a registered indicator that a request is latched.
REQ-016 The block SHALL have port STATE  out  3  the current FSM state code.

Function
REQ-017 States: CGRN=0, CYEL=1, RED1=2, WALK=3, FLASH=4, RED2=5; codes 6 and 7 SHALL go to CGRN on the next cycle.
REQ-018 PED_BTN SHALL pass through a 2-flop synchronizer and a rising-edge detector; PED_WAIT SHALL rise on the 3rd CLK edge after PED_BTN rises.
REQ-019 A detected edge SHALL set the request in states CGRN, CYEL, RED1, RED2 and SHALL be ignored in WALK and FLASH; a held button SHALL produce exactly one request.
REQ-020 The tick prescaler SHALL clear on every state entry, so a state of D ticks lasts exactly D*TICK_DIV cycles.
REQ-021 CGRN: after CAR_GREEN_MIN ticks a sticky min_done SHALL be set; the FSM SHALL enter CYEL on the first cycle with min_done and the request both set.
REQ-022 CYEL SHALL last CAR_YEL_T ticks and then enter RED1; RED1 SHALL last ALL_RED_T ticks and then enter WALK.
REQ-023 On the RED1->WALK transition cycle, the walk duration SHALL be WALK_BASE + RANDOM_WORD[RAND_BITS-1:0], sampled that cycle.
REQ-024 On that same cycle RAND_EN SHALL pulse high for exactly one cycle and the request SHALL clear; RAND_EN SHALL be 0 at all other times.
REQ-025 WALK SHALL last the sampled duration and then enter FLASH; FLASH SHALL last FLASH_T ticks and then enter RED2.
REQ-026 RED2 SHALL last ALL_RED_T ticks and then enter CGRN, where min_done starts cleared.
REQ-027 Lamps: CGRN gives CAR_GRN; CYEL gives CAR_YEL; all other states give CAR_RED; PED_GRN is on in WALK; PED_RED is on in every state except WALK and FLASH.
REQ-028 In FLASH, PED_GRN SHALL start at 1 and toggle on each tick.
REQ-029 All outputs SHALL be registered, and exactly one car lamp SHALL be on at any time.
REQ-030 Timer width SHALL hold WALK_BASE + 2^RAND_BITS - 1 without overflow.

Reset
REQ-031 While RST=0, the block SHALL hold STATE=CGRN, CAR_GRN=1, PED_RED=1, all other outputs 0, and the request, min_done, timer, prescaler and synchronizer cleared.
REQ-032 Reset mid-operation, including during WALK, SHALL return to these values immediately and asynchronously; operation SHALL resume on the first CLK edge after RST rises.

Structure
REQ-033 Package crossing_pkg SHALL hold the state encoding constants and the default timing constants.
REQ-034 Sub-module tick_gen SHALL hold the prescaler, with a synchronous clear input and a one-cycle TICK output.

Verification (TICK_DIV=4, other parameters at defaults)
REQ-035 Release reset with no press -> STATE=0, CAR_GRN=1, PED_RED=1 for 200 cycles, and RAND_EN never pulses.
REQ-036 Press 10 cycles after reset -> PED_WAIT rises on edge 13, and CYEL is entered exactly 80 cycles after reset.
REQ-037 RANDOM_WORD=16'hCAFE at RED1->WALK -> one RAND_EN pulse, and WALK lasts 14 ticks = 56 cycles.
REQ-038 FLASH -> PED_GRN follows 1,0,1,0 over four 4-cycle ticks, then RED2 lasts 8 cycles, then CGRN is entered.
REQ-039 Button held high through a full cycle plus presses during WALK -> exactly one crossing, and PED_WAIT stays 0 after RED2.
REQ-040 RST=0 asserted mid-WALK -> CAR_GRN=1, PED_GRN=0, STATE=0 with no clock edge required.
